// File: rtl/relobi_fault_tracker_if.sv
// relobi_fault_tracker_if: fault inputs, control and status outputs of the fault tracker
interface relobi_fault_tracker_if #(
  parameter int unsigned NumSources = 15,
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned IdxWidth   = (NumSources > 1) ? $clog2(NumSources) : 1
);
  logic [NumSources-1:0][1:0] fault_i;
  logic [NumSources-1:0]      src_mask_i;
  logic [CntWidth-1:0]        corr_thresh_i;
  logic                       clear_i;
  logic [CntWidth-1:0]        corr_cnt_o;
  logic [CntWidth-1:0]        uncorr_cnt_o;
  logic [NumSources-1:0]      corr_sticky_o;
  logic [NumSources-1:0]      uncorr_sticky_o;
  logic                       first_valid_o;
  logic [IdxWidth-1:0]        first_idx_o;
  logic                       first_uncorr_o;
  logic                       irq_corr_o;
  logic                       irq_uncorr_o;
  modport slave (
    input  fault_i, src_mask_i, corr_thresh_i, clear_i,
    output corr_cnt_o, uncorr_cnt_o, corr_sticky_o, uncorr_sticky_o,
           first_valid_o, first_idx_o, first_uncorr_o, irq_corr_o, irq_uncorr_o
  );
  modport master (
    output fault_i, src_mask_i, corr_thresh_i, clear_i,
    input  corr_cnt_o, uncorr_cnt_o, corr_sticky_o, uncorr_sticky_o,
           first_valid_o, first_idx_o, first_uncorr_o, irq_corr_o, irq_uncorr_o
  );
endinterface

// File: rtl/relobi_fault_tracker.sv
// relobi_fault_tracker: aggregates relobi fault pulses into counters, sticky flags,
// a first-fault record and level interrupts; every output comes straight from a flop.
module relobi_fault_tracker #(
  parameter int unsigned NumSources = 15,
  parameter int unsigned CntWidth   = 16,
  localparam int unsigned IdxWidth  = (NumSources > 1) ? $clog2(NumSources) : 1
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  relobi_fault_tracker_if.slave  bus
);
  // State encoding doubles as {first_valid, first_uncorr} so those outputs are flop bits.
  typedef enum logic [1:0] {EMPTY = 2'b00, CORR = 2'b10, UNCORR = 2'b11} state_e;
  state_e                state_q, state_d, state_b;
  logic [CntWidth-1:0]   corr_cnt_q, corr_cnt_d, corr_cnt_b;
  logic [CntWidth-1:0]   uncorr_cnt_q, uncorr_cnt_d, uncorr_cnt_b;
  logic [NumSources-1:0] corr_sticky_q, corr_sticky_d;
  logic [NumSources-1:0] uncorr_sticky_q, uncorr_sticky_d;
  logic [IdxWidth-1:0]   idx_q, idx_d, idx_b, c_idx, u_idx;
  logic                  irq_corr_q, irq_corr_d, irq_uncorr_q, irq_uncorr_d;
  logic [NumSources-1:0] c, u;
  logic                  corr_ev, uncorr_ev;
  always_comb begin
    c     = '0;
    u     = '0;
    c_idx = '0;
    u_idx = '0;
    for (int i = NumSources - 1; i >= 0; i--) begin
      u[i] = bus.fault_i[i][1] & ~bus.src_mask_i[i];
      c[i] = bus.fault_i[i][0] & ~bus.fault_i[i][1] & ~bus.src_mask_i[i];
      c_idx = c[i] ? IdxWidth'(i) : c_idx;
      u_idx = u[i] ? IdxWidth'(i) : u_idx;
    end
    corr_ev         = |c;
    uncorr_ev       = |u;
    corr_cnt_b      = bus.clear_i ? '0 : corr_cnt_q;
    uncorr_cnt_b    = bus.clear_i ? '0 : uncorr_cnt_q;
    state_b         = bus.clear_i ? EMPTY : state_q;
    idx_b           = bus.clear_i ? '0 : idx_q;
    corr_cnt_d      = (corr_ev && corr_cnt_b != '1) ? corr_cnt_b + 1'b1 : corr_cnt_b;
    uncorr_cnt_d    = (uncorr_ev && uncorr_cnt_b != '1) ? uncorr_cnt_b + 1'b1 : uncorr_cnt_b;
    corr_sticky_d   = (bus.clear_i ? '0 : corr_sticky_q) | c;
    uncorr_sticky_d = (bus.clear_i ? '0 : uncorr_sticky_q) | u;
    state_d         = state_b;
    idx_d           = idx_b;
    if (state_b != UNCORR && uncorr_ev) begin
      state_d = UNCORR;
      idx_d   = u_idx;
    end else if (state_b == EMPTY && corr_ev) begin
      state_d = CORR;
      idx_d   = c_idx;
    end
    irq_uncorr_d = |uncorr_sticky_d;
    irq_corr_d   = (bus.corr_thresh_i != '0) && (corr_cnt_d >= bus.corr_thresh_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= EMPTY;
      idx_q           <= '0;
      corr_cnt_q      <= '0;
      uncorr_cnt_q    <= '0;
      corr_sticky_q   <= '0;
      uncorr_sticky_q <= '0;
      irq_corr_q      <= 1'b0;
      irq_uncorr_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      corr_cnt_q      <= corr_cnt_d;
      uncorr_cnt_q    <= uncorr_cnt_d;
      corr_sticky_q   <= corr_sticky_d;
      uncorr_sticky_q <= uncorr_sticky_d;
      irq_corr_q      <= irq_corr_d;
      irq_uncorr_q    <= irq_uncorr_d;
    end
  end
  assign bus.corr_cnt_o      = corr_cnt_q;
  assign bus.uncorr_cnt_o    = uncorr_cnt_q;
  assign bus.corr_sticky_o   = corr_sticky_q;
  assign bus.uncorr_sticky_o = uncorr_sticky_q;
  assign bus.first_valid_o   = state_q[1];
  assign bus.first_uncorr_o  = state_q[0];
  assign bus.first_idx_o     = idx_q;
  assign bus.irq_corr_o      = irq_corr_q;
  assign bus.irq_uncorr_o    = irq_uncorr_q;
endmodule

// File: tb/tb_relobi_fault_tracker.sv
// tb_relobi_fault_tracker: directed steps with hand-computed expectations, one 16-bit
// counter instance for function and one 4-bit counter instance for saturation.
module tb_relobi_fault_tracker;
  logic clk_i = 1'b0;
  logic rst_ni;
  int total = 0;
  int bad = 0;
  always #5 clk_i = ~clk_i;
  relobi_fault_tracker_if #(.NumSources(15), .CntWidth(16)) a ();
  relobi_fault_tracker_if #(.NumSources(15), .CntWidth(4))  b ();
  relobi_fault_tracker #(.NumSources(15), .CntWidth(16)) dut  (.clk_i(clk_i), .rst_ni(rst_ni), .bus(a));
  relobi_fault_tracker #(.NumSources(15), .CntWidth(4))  dut4 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_ccnt"}, 32'(a.corr_cnt_o), 32'd0);
    chk({tag, "_ucnt"}, 32'(a.uncorr_cnt_o), 32'd0);
    chk({tag, "_cst"}, 32'(a.corr_sticky_o), 32'd0);
    chk({tag, "_ust"}, 32'(a.uncorr_sticky_o), 32'd0);
    chk({tag, "_fv"}, 32'(a.first_valid_o), 32'd0);
    chk({tag, "_fidx"}, 32'(a.first_idx_o), 32'd0);
    chk({tag, "_fu"}, 32'(a.first_uncorr_o), 32'd0);
    chk({tag, "_irqc"}, 32'(a.irq_corr_o), 32'd0);
    chk({tag, "_irqu"}, 32'(a.irq_uncorr_o), 32'd0);
  endtask
  initial begin
    rst_ni = 1'b0;
    a.fault_i = '0; a.src_mask_i = '0; a.corr_thresh_i = '0; a.clear_i = 1'b0;
    b.fault_i = '0; b.src_mask_i = '0; b.corr_thresh_i = '0; b.clear_i = 1'b0;
    #12;
    chk_all_zero("reset");
    tick();
    rst_ni = 1'b1;
    tick();
    a.fault_i[3] = 2'b01;
    tick();
    a.fault_i = '0;
    chk("single_ccnt", 32'(a.corr_cnt_o), 32'd1);
    chk("single_cst", 32'(a.corr_sticky_o), 32'h0008);
    chk("single_fv", 32'(a.first_valid_o), 32'd1);
    chk("single_fidx", 32'(a.first_idx_o), 32'd3);
    chk("single_fu", 32'(a.first_uncorr_o), 32'd0);
    chk("single_irqu", 32'(a.irq_uncorr_o), 32'd0);
    a.fault_i[9] = 2'b11;
    a.fault_i[12] = 2'b10;
    tick();
    a.fault_i = '0;
    chk("upg_ucnt", 32'(a.uncorr_cnt_o), 32'd1);
    chk("upg_ccnt", 32'(a.corr_cnt_o), 32'd1);
    chk("upg_ust", 32'(a.uncorr_sticky_o), 32'h1200);
    chk("upg_cst", 32'(a.corr_sticky_o), 32'h0008);
    chk("upg_fidx", 32'(a.first_idx_o), 32'd9);
    chk("upg_fu", 32'(a.first_uncorr_o), 32'd1);
    chk("upg_irqu", 32'(a.irq_uncorr_o), 32'd1);
    a.fault_i[0] = 2'b10;
    tick();
    a.fault_i = '0;
    chk("frozen_fidx", 32'(a.first_idx_o), 32'd9);
    chk("frozen_ucnt", 32'(a.uncorr_cnt_o), 32'd2);
    chk("frozen_ust", 32'(a.uncorr_sticky_o), 32'h1201);
    a.corr_thresh_i = 16'd4;
    a.fault_i[1] = 2'b01;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("thr_ccnt", 32'(a.corr_cnt_o), 32'(k));
      chk("thr_irqc", 32'(a.irq_corr_o), (k >= 4) ? 32'd1 : 32'd0);
    end
    a.fault_i = '0;
    a.corr_thresh_i = 16'd0;
    chk("thr0_before", 32'(a.irq_corr_o), 32'd1);
    tick();
    chk("thr0_after", 32'(a.irq_corr_o), 32'd0);
    chk("thr0_cst", 32'(a.corr_sticky_o), 32'h000A);
    a.fault_i[1] = 2'b01;
    repeat (3) tick();
    a.fault_i = '0;
    chk("pre_clr_ccnt", 32'(a.corr_cnt_o), 32'd7);
    a.clear_i = 1'b1;
    a.fault_i[2] = 2'b01;
    tick();
    a.clear_i = 1'b0;
    a.fault_i = '0;
    chk("clr_ccnt", 32'(a.corr_cnt_o), 32'd1);
    chk("clr_cst", 32'(a.corr_sticky_o), 32'h0004);
    chk("clr_fidx", 32'(a.first_idx_o), 32'd2);
    chk("clr_fv", 32'(a.first_valid_o), 32'd1);
    chk("clr_fu", 32'(a.first_uncorr_o), 32'd0);
    chk("clr_ucnt", 32'(a.uncorr_cnt_o), 32'd0);
    chk("clr_ust", 32'(a.uncorr_sticky_o), 32'd0);
    chk("clr_irqu", 32'(a.irq_uncorr_o), 32'd0);
    a.src_mask_i[5] = 1'b1;
    a.fault_i[5] = 2'b10;
    tick();
    chk("mask_ucnt", 32'(a.uncorr_cnt_o), 32'd0);
    chk("mask_ust", 32'(a.uncorr_sticky_o), 32'd0);
    chk("mask_irqu", 32'(a.irq_uncorr_o), 32'd0);
    chk("mask_fu", 32'(a.first_uncorr_o), 32'd0);
    chk("mask_fidx", 32'(a.first_idx_o), 32'd2);
    a.fault_i[5] = 2'b01;
    tick();
    chk("mask_ccnt", 32'(a.corr_cnt_o), 32'd1);
    chk("mask_cst", 32'(a.corr_sticky_o), 32'h0004);
    a.fault_i = '0;
    a.src_mask_i = 15'h0004;
    tick();
    chk("mask_keep_cst", 32'(a.corr_sticky_o), 32'h0004);
    a.src_mask_i = '0;
    a.fault_i[7] = 2'b10;
    tick();
    a.fault_i = '0;
    chk("pre_rst_ucnt", 32'(a.uncorr_cnt_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2;
    rst_ni = 1'b1;
    tick();
    a.fault_i[4] = 2'b01;
    tick();
    a.fault_i = '0;
    chk("post_rst_fv", 32'(a.first_valid_o), 32'd1);
    chk("post_rst_fidx", 32'(a.first_idx_o), 32'd4);
    chk("post_rst_fu", 32'(a.first_uncorr_o), 32'd0);
    chk("post_rst_ccnt", 32'(a.corr_cnt_o), 32'd1);
    b.corr_thresh_i = 4'd15;
    b.fault_i[0] = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("sat_ccnt", 32'(b.corr_cnt_o), (k < 15) ? 32'(k) : 32'd15);
      chk("sat_irqc", 32'(b.irq_corr_o), (k >= 15) ? 32'd1 : 32'd0);
    end
    b.fault_i = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/relobi_fault_tracker.md
# relobi_fault_tracker

Fault aggregation stage that consumes the 2-bit `fault_o` vectors produced by the reliable-OBI crossbar, its manager-side encoders and its subordinate-side decoders. It turns the transient per-cycle fault pulses into saturating event counters, per-source sticky flags, a first-fault capture record and two level interrupts. It sits directly downstream of the relobi fabric's fault outputs and feeds the SoC interrupt controller and the status registers.

## Interface
- `NumSources`, default 15: number of fault sources (for example 6 encoders + 8 decoders + 1 crossbar).
- `CntWidth`, default 16: width of each event counter.
- `IdxWidth`, default `cf_math_pkg::idx_width(NumSources)`: width of the captured source index. Derived; do not override.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `fault_i`, in, `[NumSources-1:0][1:0]`: per-source fault. Bit 0 is corrected, bit 1 is uncorrectable.
- `src_mask_i`, in, `NumSources`: 1 = ignore that source entirely.
- `corr_thresh_i`, in, `CntWidth`: corrected-count interrupt threshold. 0 disables `irq_corr_o`.
- `clear_i`, in, 1: synchronous clear of all state.
- `corr_cnt_o`, out, `CntWidth`: corrected-event cycle count.
- `uncorr_cnt_o`, out, `CntWidth`: uncorrectable-event cycle count.
- `corr_sticky_o`, out, `NumSources`: sources that have reported a corrected fault.
- `uncorr_sticky_o`, out, `NumSources`: sources that have reported an uncorrectable fault.
- `first_valid_o`, out, 1: a fault has been captured.
- `first_idx_o`, out, `IdxWidth`: index of the captured source.
- `first_uncorr_o`, out, 1: the captured fault is uncorrectable.
- `irq_corr_o`, out, 1: corrected-count threshold reached (level).
- `irq_uncorr_o`, out, 1: at least one uncorrectable fault is recorded (level).

## Operation
- **Per-source qualification.**
  - `u[i] = fault_i[i][1] & ~src_mask_i[i]`.
  - `c[i] = fault_i[i][0] & ~fault_i[i][1] & ~src_mask_i[i]`.
  - If both bits are set on one source, that source counts as uncorrectable only.
- **Event flags.** `corr_ev = |c`, `uncorr_ev = |u`. Counters count event cycles, not sources: 5 sources faulting in one cycle add 1.
- **Base state.** `base = clear_i ? reset state : current state`. The next state is `base` updated with this cycle's events, so a fault coincident with `clear_i` is never lost.
- **Counters.** `next = base + ev`, saturating at all-ones. The counter holds at saturation and never wraps.
- **Sticky flags.** `next = base | c` for the corrected flags and `base | u` for the uncorrectable flags.
- **First-fault capture.** A small FSM on (`first_valid`, `first_uncorr`), with states EMPTY, CORR and UNCORR:
  - EMPTY → UNCORR when `uncorr_ev`. Capture the lowest index with `u` set.
  - EMPTY → CORR when `corr_ev` and no `uncorr_ev`. Capture the lowest index with `c` set.
  - CORR → UNCORR when `uncorr_ev`. Overwrite the index with the lowest `u` index; this upgrade happens once.
  - CORR stays in CORR on further corrected events; the index does not change.
  - UNCORR is frozen until clear or reset.
  - `clear_i` evaluates the FSM from EMPTY.
- **`irq_uncorr_o`.** Registered; equals `|next uncorr_sticky`.
- **`irq_corr_o`.** Registered; equals `(corr_thresh_i != 0) && (next corr_cnt >= corr_thresh_i)`. It deasserts only on clear, reset, or a threshold change that makes the compare false.
- **Masking.** A masked source affects nothing: counters, sticky flags, capture and interrupts are all unaffected. Changing the mask does not erase state already recorded.

## Timing
- **Reset values.** All outputs are 0 on reset: counters, sticky flags, `first_valid_o`, `first_idx_o`, `first_uncorr_o` and both irqs. The reset is asynchronous assert, with release synchronous to `clk_i`. Reset mid-operation discards all state immediately.
- **Latency.** Every output is a flop. A fault sampled at edge N is visible after edge N and stable during cycle N+1. There is no combinational path from input to output.
- **Clear.** `clear_i` sampled at edge N zeroes the state visible in cycle N+1, except for events sampled in the same cycle.
- **Threshold changes.** A change to `corr_thresh_i` is reflected in `irq_corr_o` one cycle later.
- **Throughput.** One event per cycle per class, sustained indefinitely. There is no backpressure and no handshake.

## Test plan
- **Single corrected fault.** Pulse `fault_i[3]=2'b01` for 1 cycle. Required response after one cycle: `corr_cnt_o=1`, `corr_sticky_o=15'h0008`, `first_valid_o=1`, `first_idx_o=3`, `first_uncorr_o=0`, `irq_uncorr_o=0`.
- **Upgrade and dual-bit fault.** Start from the previous state and pulse `fault_i[9]=2'b11` together with `fault_i[12]=2'b10`. Required response:
  - `uncorr_cnt_o=1`; `corr_cnt_o` stays 1.
  - `uncorr_sticky_o` has bits 9 and 12 set.
  - `first_idx_o=9`, `first_uncorr_o=1`, `irq_uncorr_o=1`.
  - A later `fault_i[0]=2'b10` leaves `first_idx_o` at 9.
- **Threshold.** Set `corr_thresh_i=4` and hold `fault_i[1]=2'b01` for 4 cycles. Required response:
  - `irq_corr_o` rises in the same cycle `corr_cnt_o` reads 4.
  - Setting `corr_thresh_i=0` drops `irq_corr_o` one cycle later.
- **Saturation.** Use `CntWidth=4` and hold a corrected fault for 20 cycles. Required response: `corr_cnt_o` climbs to 15 and stays at 15.
- **Clear versus fault, and masking.**
  - Assert `clear_i` in the same cycle as `fault_i[2]=2'b01`, with `corr_cnt_o=7` beforehand. Required response: `corr_cnt_o=1`, sticky `=15'h0004`, `first_idx_o=2`.
  - With `src_mask_i[5]=1`, drive `fault_i[5]=2'b10`. Required response: no output changes.
- **Async reset mid-stream.** Drop `rst_ni` between clock edges while the counters are nonzero. Required response: all outputs read 0 before the next edge. After release, the first fault is captured as from EMPTY.
